// File: rtl/crtc_timing_gen.sv
// PET CRTC raster timing: character tick, MA/RA, display enable, H/V sync, frame start.
// Define CRTC_CURSOR_EN to add the hardware cursor and its blink frame counter.
module crtc_timing_gen #(
  parameter int CHAR_DIV = 16
) (
  input  logic         clk16,
  input  logic         res_b,
  input  logic [127:0] crtc_regs,
  output logic         char_en,
  output logic [13:0]  ma,
  output logic [4:0]   ra,
  output logic         de,
  output logic         hsync,
  output logic         vsync,
  output logic         cursor,
  output logic         frame_start
);

  localparam int PW = $clog2(CHAR_DIV);

  logic [7:0]    r_s [0:15];
  logic [PW-1:0] presc_r;
  logic          tick_s;
  logic [7:0]    h_r, h_nxt_s;
  logic [4:0]    ra_r, ra_nxt_s;
  logic [6:0]    row_r, row_nxt_s;
  logic          adj_r, adj_nxt_s;
  logic [13:0]   ma_row_r, ma_row_nxt_s;
  logic          frame_end_s;
  logic [3:0]    hs_cnt_r;
  logic [3:0]    vs_cnt_r;
  logic [13:0]   ma_s;
  logic          de_s;
  logic          vs_trig_s;
  logic          cur_s;

  // Split the flat register bus into R0..R15
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      r_s[i] = crtc_regs[8*i +: 8];
    end
  end

  assign tick_s  = (presc_r == PW'(CHAR_DIV - 1));
  assign char_en = tick_s;

  // Character-rate prescaler
  always_ff @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + 1'b1;
    end
  end

  // Next raster position; >= compares let shrunk limits end the count at once
  always_comb begin
    h_nxt_s      = h_r + 8'd1;
    ra_nxt_s     = ra_r;
    row_nxt_s    = row_r;
    adj_nxt_s    = adj_r;
    ma_row_nxt_s = ma_row_r;
    frame_end_s  = 1'b0;
    if (h_r >= r_s[0]) begin
      h_nxt_s = 8'd0;
      if (adj_r) begin
        ra_nxt_s    = ra_r + 5'd1;
        frame_end_s = (({1'b0, ra_r} + 6'd1) >= {1'b0, r_s[5][4:0]});
      end else if (ra_r >= r_s[9][4:0]) begin
        ra_nxt_s     = 5'd0;
        ma_row_nxt_s = ma_row_r + {6'd0, r_s[1]};
        row_nxt_s    = row_r + 7'd1;
        if (row_r >= r_s[4][6:0]) begin
          adj_nxt_s   = (r_s[5][4:0] != 5'd0);
          frame_end_s = (r_s[5][4:0] == 5'd0);
        end else begin
          adj_nxt_s = 1'b0;
        end
      end else begin
        ra_nxt_s = ra_r + 5'd1;
      end
    end else begin
      h_nxt_s = h_r + 8'd1;
    end
    // Frame end overrides any row advance and reloads the start address
    row_nxt_s    = frame_end_s ? 7'd0 : row_nxt_s;
    ra_nxt_s     = frame_end_s ? 5'd0 : ra_nxt_s;
    adj_nxt_s    = frame_end_s ? 1'b0 : adj_nxt_s;
    ma_row_nxt_s = frame_end_s ? {r_s[12][5:0], r_s[13]} : ma_row_nxt_s;
  end

  // Raster counters advance once per character
  always_ff @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      h_r      <= 8'd0;
      ra_r     <= 5'd0;
      row_r    <= 7'd0;
      adj_r    <= 1'b0;
      ma_row_r <= 14'd0;
    end else if (tick_s) begin
      h_r      <= h_nxt_s;
      ra_r     <= ra_nxt_s;
      row_r    <= row_nxt_s;
      adj_r    <= adj_nxt_s;
      ma_row_r <= ma_row_nxt_s;
    end
  end

  assign ma_s      = ma_row_r + {6'd0, h_r};
  assign de_s      = (h_r < r_s[1]) && (row_r < r_s[6][6:0]) && !adj_r;
  assign vs_trig_s = (row_r == r_s[7][6:0]) && (ra_r == 5'd0) && !adj_r;

`ifdef CRTC_CURSOR_EN
  logic [4:0] frame_cnt_r;
  logic       blink_s;

  // Frame counter drives the cursor blink
  always_ff @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      frame_cnt_r <= 5'd0;
    end else if (tick_s && frame_end_s) begin
      frame_cnt_r <= frame_cnt_r + 5'd1;
    end
  end

  // Blink mode select from R10[6:5]
  always_comb begin
    blink_s = 1'b0;
    case (r_s[10][6:5])
      2'b00:   blink_s = 1'b1;
      2'b01:   blink_s = 1'b0;
      2'b10:   blink_s = frame_cnt_r[3];
      2'b11:   blink_s = frame_cnt_r[4];
      default: blink_s = 1'b0;
    endcase
  end

  assign cur_s = de_s && (ma_s == {r_s[14][5:0], r_s[15]}) &&
                 (ra_r >= r_s[10][4:0]) && (ra_r <= r_s[11][4:0]) && blink_s;
`else
  assign cur_s = 1'b0;
`endif

  // Registered outputs describe the character the counters held at the tick
  always_ff @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      ma          <= 14'd0;
      ra          <= 5'd0;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      cursor      <= 1'b0;
      frame_start <= 1'b0;
      hs_cnt_r    <= 4'd0;
      vs_cnt_r    <= 4'd0;
    end else if (tick_s) begin
      ma          <= ma_s;
      ra          <= ra_r;
      de          <= de_s;
      cursor      <= cur_s;
      frame_start <= (h_r == 8'd0) && (row_r == 7'd0) && (ra_r == 5'd0) && !adj_r;
      if ((h_r == r_s[2]) && (r_s[3][3:0] != 4'd0)) begin
        hsync    <= 1'b1;
        hs_cnt_r <= r_s[3][3:0] - 4'd1;
      end else if (hs_cnt_r != 4'd0) begin
        hs_cnt_r <= hs_cnt_r - 4'd1;
      end else begin
        hsync <= 1'b0;
      end
      // Width field 0 wraps to 15 remaining, i.e. 16 lines
      if (h_r == 8'd0) begin
        if (vs_trig_s) begin
          vsync    <= 1'b1;
          vs_cnt_r <= r_s[3][7:4] - 4'd1;
        end else if (vs_cnt_r != 4'd0) begin
          vs_cnt_r <= vs_cnt_r - 4'd1;
        end else begin
          vsync <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_crtc_timing_gen.sv
// Bench for crtc_timing_gen: frame-level model built from nested row/line/char loops,
// compared every clk16 cycle, plus directed register-rewrite and reset checks.
module tb_crtc_timing_gen;

  typedef struct packed {
    logic [13:0] ma;
    logic [4:0]  ra;
    logic        de;
    logic        hs;
    logic        vs;
    logic        cur;
    logic        fs;
  } exp_t;

  logic         clk16 = 1'b0;
  logic         res_b;
  logic [127:0] crtc_regs;
  logic         char_en;
  logic [13:0]  ma;
  logic [4:0]   ra;
  logic         de, hsync, vsync, cursor, frame_start;

  int   total = 0;
  int   bad = 0;
  int   edge_cnt;
  bit   chk_on = 1'b0;
  exp_t exp_q[$];
  bit   hs_hist[$];
  bit   vs_hist[$];
  int   c_r0, c_r1, c_r2, c_r6, c_r7, c_hlen, c_vlen, c_caddr, c_cur_lo, c_cur_hi, c_mode;

  crtc_timing_gen dut (
    .clk16(clk16), .res_b(res_b), .crtc_regs(crtc_regs), .char_en(char_en),
    .ma(ma), .ra(ra), .de(de), .hsync(hsync), .vsync(vsync),
    .cursor(cursor), .frame_start(frame_start)
  );

  always #5 clk16 = ~clk16;

  always @(posedge clk16 or negedge res_b) begin
    if (!res_b) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 30) $display("FAIL %s actual=%0h required=%0h edge=%0d", name, act, req, edge_cnt);
    end
  endtask

  function automatic int rg(input int n);
    return int'(crtc_regs[8*n +: 8]);
  endfunction

  task automatic set_reg(input int n, input int v);
    crtc_regs[8*n +: 8] = 8'(v);
  endtask

  function automatic bit blink(input int mode, input int fc);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return fc[3];
      default: return fc[4];
    endcase
  endfunction

  // One raster line of expected outputs
  task automatic emit(input int f, input int row, input int l, input bit adj, input int mrow);
    exp_t e;
    bit   vs = 1'b0;
    vs_hist.push_back((row == c_r7) && (l == 0) && !adj);
    for (int k = 0; k < c_vlen && k < vs_hist.size(); k++) if (vs_hist[$-k]) vs = 1'b1;
    for (int h = 0; h <= c_r0; h++) begin
      hs_hist.push_back(h == c_r2);
      e.hs = 1'b0;
      for (int k = 0; k < c_hlen && k < hs_hist.size(); k++) if (hs_hist[$-k]) e.hs = 1'b1;
      e.ma = 14'((mrow + h) % 16384);
      e.ra = 5'(l);
      e.de = (h < c_r1) && (row < c_r6) && !adj;
      e.vs = vs;
      e.fs = (h == 0) && (row == 0) && (l == 0) && !adj;
`ifdef CRTC_CURSOR_EN
      e.cur = e.de && (int'(e.ma) == c_caddr) && (l >= c_cur_lo) && (l <= c_cur_hi) &&
              blink(c_mode, f % 32);
`else
      e.cur = 1'b0;
`endif
      exp_q.push_back(e);
    end
  endtask

  // Expected character stream for nframes frames from reset with the current registers
  task automatic build(input int nframes);
    int r4, r5, r9, start, base;
    exp_q.delete(); hs_hist.delete(); vs_hist.delete();
    c_r0 = rg(0); c_r1 = rg(1); c_r2 = rg(2); c_r6 = rg(6) & 127; c_r7 = rg(7) & 127;
    c_hlen = rg(3) & 15;
    c_vlen = ((rg(3) >> 4) == 0) ? 16 : (rg(3) >> 4);
    c_caddr = ((rg(14) & 63) << 8) | rg(15);
    c_cur_lo = rg(10) & 31; c_cur_hi = rg(11) & 31; c_mode = (rg(10) >> 5) & 3;
    r4 = rg(4) & 127; r5 = rg(5) & 31; r9 = rg(9) & 31;
    start = ((rg(12) & 63) << 8) | rg(13);
    for (int f = 0; f < nframes; f++) begin
      base = (f == 0) ? 0 : start;
      for (int row = 0; row <= r4; row++)
        for (int l = 0; l <= r9; l++) emit(f, row, l, 1'b0, (base + row * rg(1)) % 16384);
      for (int l = 0; l < r5; l++) emit(f, r4 + 1, l, 1'b1, (base + (r4 + 1) * rg(1)) % 16384);
    end
  endtask

  task automatic do_reset();
    @(negedge clk16);
    res_b = 1'b0;
    repeat (3) @(negedge clk16);
    #2 res_b = 1'b1;
  endtask

  task automatic run_model(input int nchars);
    do_reset();
    chk_on = 1'b1;
    repeat (16 * nchars + 8) @(posedge clk16);
    @(negedge clk16);
    chk_on = 1'b0;
  endtask

  task automatic load_reset_regs();
    crtc_regs = '0;
    set_reg(0, 'h31); set_reg(1, 'h28); set_reg(2, 'h29); set_reg(3, 'h0F); set_reg(4, 'h28);
    set_reg(5, 'h05); set_reg(6, 'h19); set_reg(7, 'h21); set_reg(9, 'h07);
  endtask

  int   ck;
  exp_t ev;
  // Every-cycle comparison against the model
  always @(negedge clk16) begin
    if (chk_on) begin
      ck = edge_cnt;
      check("char_en", 32'(char_en), 32'(ck % 16 == 15));
      if (ck < 16) ev = '0;
      else         ev = exp_q[ck / 16 - 1];
      check("outputs", 32'({ma, ra, de, hsync, vsync, cursor, frame_start}), 32'(ev));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit found;
    res_b = 1'b0;
    crtc_regs = '0;
    #1 check("reset_outs", 32'({char_en, ma, ra, de, hsync, vsync, cursor, frame_start}), 32'd0);

    // Power-on register set: 50-char lines, 333-line frame
    load_reset_regs();
    build(1);
    check("pin_frame_chars", exp_q.size(), 16650);
    check("pin_line_ra0", 32'(exp_q[49].ra), 32'd0);
    check("pin_line_ra1", 32'(exp_q[50].ra), 32'd1);
    check("pin_hs40", 32'(exp_q[40].hs), 32'd0);
    check("pin_hs41", 32'(exp_q[41].hs), 32'd1);
    check("pin_hs55", 32'(exp_q[55].hs), 32'd1);
    check("pin_hs56", 32'(exp_q[56].hs), 32'd0);
    check("pin_de39", 32'(exp_q[39].de), 32'd1);
    check("pin_de40", 32'(exp_q[40].de), 32'd0);
    check("pin_de_last", 32'(exp_q[199*50].de), 32'd1);
    check("pin_de_200", 32'(exp_q[200*50].de), 32'd0);
    check("pin_row1_ma", 32'(exp_q[400].ma), 32'h28);
    check("pin_vs_pre", 32'(exp_q[13199].vs), 32'd0);
    check("pin_vs_on", 32'(exp_q[13200].vs), 32'd1);
    check("pin_vs_end", 32'(exp_q[13999].vs), 32'd1);
    check("pin_vs_off", 32'(exp_q[14000].vs), 32'd0);
    run_model(150);

    // Small frame: start-address reload, MA wrap, hsync wrap, vsync across frame end
    crtc_regs = '0;
    set_reg(0, 9); set_reg(1, 6); set_reg(2, 8); set_reg(3, 'h74); set_reg(4, 3);
    set_reg(5, 2); set_reg(6, 3); set_reg(7, 3); set_reg(9, 2);
    set_reg(12, 'h3F); set_reg(13, 'hF0);
    build(3);
    check("pin_a_first_ma", 32'(exp_q[0].ma), 32'h0);
    check("pin_a_f1_ma", 32'(exp_q[140].ma), 32'h3FF0);
    check("pin_a_f1_fs", 32'(exp_q[140].fs), 32'd1);
    check("pin_a_row1", 32'(exp_q[170].ma), 32'h3FF6);
    check("pin_a_3fff", 32'(exp_q[203].ma), 32'h3FFF);
    check("pin_a_wrap", 32'(exp_q[204].ma), 32'h0);
    check("pin_a_row3", 32'(exp_q[230].ma), 32'h2);
    check("pin_a_hs7", 32'(exp_q[7].hs), 32'd0);
    check("pin_a_hs11", 32'(exp_q[11].hs), 32'd1);
    check("pin_a_hs12", 32'(exp_q[12].hs), 32'd0);
    check("pin_a_vs89", 32'(exp_q[89].vs), 32'd0);
    check("pin_a_vs90", 32'(exp_q[90].vs), 32'd1);
    check("pin_a_vs159", 32'(exp_q[159].vs), 32'd1);
    check("pin_a_vs160", 32'(exp_q[160].vs), 32'd0);
    run_model(420);

    // R0 shrunk below the running count mid-line
    load_reset_regs();
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk16);
      if (ma == 14'd19) found = 1'b1;
    end
    check("rw_wait_h19", 32'(found), 32'd1);
    set_reg(0, 'h10);
    repeat (16) @(negedge clk16);
    check("rw_h20", 32'({ma, ra}), 32'({14'd20, 5'd0}));
    repeat (16) @(negedge clk16);
    check("rw_wrap", 32'({ma, ra}), 32'({14'd0, 5'd1}));
    repeat (256) @(negedge clk16);
    check("rw_h16", 32'({ma, ra}), 32'({14'd16, 5'd1}));
    repeat (16) @(negedge clk16);
    check("rw_next", 32'({ma, ra}), 32'({14'd0, 5'd2}));

    // Asynchronous reset mid-line, then restart
    repeat (37) @(negedge clk16);
    #2 res_b = 1'b0;
    #1 check("async_rst", 32'({char_en, ma, ra, de, hsync, vsync, cursor, frame_start}), 32'd0);
    @(negedge clk16);
    #2 res_b = 1'b1;
    repeat (15) @(posedge clk16);
    #1 check("restart_15", 32'({frame_start, char_en}), 32'b01);
    @(posedge clk16);
    #1 check("restart_16", 32'({frame_start, ma, ra, de}), 32'({1'b1, 14'd0, 5'd0, 1'b1}));

    // Tiny frame for cursor blink over 20 frames
    crtc_regs = '0;
    set_reg(0, 3); set_reg(1, 3); set_reg(2, 2); set_reg(3, 'h01); set_reg(4, 0);
    set_reg(5, 0); set_reg(6, 1); set_reg(7, 0); set_reg(9, 1);
    set_reg(10, 'h40); set_reg(11, 'h07); set_reg(14, 0); set_reg(15, 2);
    build(20);
    check("pin_b_frame", exp_q.size(), 160);
    check("pin_b_fs8", 32'(exp_q[64].fs), 32'd1);
`ifdef CRTC_CURSOR_EN
    check("pin_b_cur_f0", 32'(exp_q[2].cur), 32'd0);
    check("pin_b_cur_f8", 32'(exp_q[66].cur), 32'd1);
    check("pin_b_cur_ra1", 32'(exp_q[70].cur), 32'd1);
    check("pin_b_cur_h3", 32'(exp_q[67].cur), 32'd0);
    check("pin_b_cur_f16", 32'(exp_q[130].cur), 32'd0);
`else
    check("pin_b_cur_off", 32'(exp_q[66].cur), 32'd0);
`endif
    run_model(160);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
